mem_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Consumes the registered EX/MEM outputs of the execute stage.
- Resolves branches: pcsrc = branch & zero.
- Performs data-memory loads and stores against an internal word RAM with configurable multi-cycle latency. Stalls the front of the pipe while an access is in flight.
- Drives the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: branch resolve, multi-cycle data RAM access, MEM/WB register.
// Optional misalignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int DEPTH_LOG2  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] EX_MEM_NPC,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        mem_stall,
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        align_err
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam bit        MULTI  = (MEM_LATENCY > 1);
    localparam logic [3:0] CNT_LD = MULTI ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_req;
    logic        w_stall;
    logic        w_done;
    logic        w_misalign;
    logic [DEPTH_LOG2-1:0] w_idx;

    logic [31:0] r_ram [2**DEPTH_LOG2];
    logic [1:0]  r_wb_ctl;
    logic [31:0] r_read_data;
    logic [31:0] r_alu;
    logic [4:0]  r_wreg;

    assign w_req = memread | memwrite;
    assign w_idx = alu_result[DEPTH_LOG2+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_req & (alu_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && MULTI) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_LD;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Instruction retires in any non-stalled, non-reset cycle
    assign w_done = ~w_stall & ~reset;

    always_ff @(posedge clk) begin
        if (w_done && memwrite && !w_misalign)
            r_ram[w_idx] <= rdata2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_ctl    <= 2'b00;
            r_read_data <= 32'd0;
            r_alu       <= 32'd0;
            r_wreg      <= 5'd0;
        end else if (w_stall) begin
            r_wb_ctl <= 2'b00;
        end else begin
            r_wb_ctl    <= wb_ctl;
            r_alu       <= alu_result;
            r_wreg      <= five_bit_muxout;
            r_read_data <= (memread && !w_misalign) ? r_ram[w_idx] : 32'd0;
        end
    end

    assign mem_stall      = w_stall & ~reset;
    assign pcsrc          = branch & zero & ~mem_stall;
    assign branch_target  = EX_MEM_NPC;
    assign align_err      = w_done & w_misalign;
    assign wb_ctlout      = r_wb_ctl;
    assign read_data      = r_read_data;
    assign mem_alu_result = r_alu;
    assign mem_write_reg  = r_wreg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-mid-access sequence,
// and random instructions against a transaction-level model (LAT 1 and 3).
module tb_mem_stage;

    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        zero;
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic        pcsrc;
        logic [31:0] bt;
        logic        stall;
        logic [1:0]  wbc;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        aerr;
    } out_t;

    typedef struct {
        int          d;
        in_t         i;
        bit          chk;
        logic [31:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    in_t  in0, in1;
    out_t o0, o1;

    logic        p0, s0, a0, p1, s1, a1;
    logic [31:0] bt0, rd0, al0, bt1, rd1, al1;
    logic [1:0]  wb0, wb1;
    logic [4:0]  wr0, wr1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mm [2][256];
    out_t        e  [2];
    bit          stale [2];

    always #5 clk = ~clk;

    mem_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .wb_ctl(in0.wb_ctl), .branch(in0.branch),
        .memread(in0.memread), .memwrite(in0.memwrite), .zero(in0.zero),
        .EX_MEM_NPC(in0.npc), .alu_result(in0.alu), .rdata2(in0.wdata),
        .five_bit_muxout(in0.rd), .pcsrc(p0), .branch_target(bt0),
        .mem_stall(s0), .wb_ctlout(wb0), .read_data(rd0),
        .mem_alu_result(al0), .mem_write_reg(wr0), .align_err(a0)
    );

    mem_stage #(.DEPTH_LOG2(8), .MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .wb_ctl(in1.wb_ctl), .branch(in1.branch),
        .memread(in1.memread), .memwrite(in1.memwrite), .zero(in1.zero),
        .EX_MEM_NPC(in1.npc), .alu_result(in1.alu), .rdata2(in1.wdata),
        .five_bit_muxout(in1.rd), .pcsrc(p1), .branch_target(bt1),
        .mem_stall(s1), .wb_ctlout(wb1), .read_data(rd1),
        .mem_alu_result(al1), .mem_write_reg(wr1), .align_err(a1)
    );

    assign o0 = {p0, bt0, s0, wb0, rd0, al0, wr0, a0};
    assign o1 = {p1, bt1, s1, wb1, rd1, al1, wr1, a1};

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic out_t get(input int d);
        return (d == 0) ? o0 : o1;
    endfunction

    function automatic in_t mk(input logic [1:0] wb, input logic br,
                               input logic rd_, input logic wr_,
                               input logic z, input logic [31:0] npc,
                               input logic [31:0] alu,
                               input logic [31:0] wd,
                               input logic [4:0] rd);
        in_t v;
        v.wb_ctl = wb; v.branch = br; v.memread = rd_; v.memwrite = wr_;
        v.zero = z; v.npc = npc; v.alu = alu; v.wdata = wd; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input in_t v);
        if (d == 0) in0 = v;
        else in1 = v;
    endtask

    task automatic check_regs(input int d, input string tag);
        out_t o;
        o = get(d);
        chk({tag, " wb_ctlout"}, 32'(o.wbc), 32'(e[d].wbc));
        chk({tag, " read_data"}, o.rdat, e[d].rdat);
        chk({tag, " mem_alu_result"}, o.alu, e[d].alu);
        chk({tag, " mem_write_reg"}, 32'(o.wreg), 32'(e[d].wreg));
    endtask

    // One instruction: req costs LAT cycles (LAT-1 stalls), else 1 cycle.
    task automatic issue(input int d, input in_t v);
        int n;
        bit req, stl;
        logic [7:0] idx;
        out_t o;
        string tag;
        tag = (d == 0) ? "L1" : "L3";
        if (stale[d]) begin
            e[d].wbc = 0; e[d].rdat = 0; e[d].alu = 0; e[d].wreg = 0;
            stale[d] = 0;
        end
        drive(d, v);
        req = v.memread | v.memwrite;
        n = (req && lat(d) > 1) ? lat(d) : 1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            stl = (c < n - 1);
            o = get(d);
            chk({tag, " mem_stall"}, 32'(o.stall), 32'(stl));
            chk({tag, " pcsrc"}, 32'(o.pcsrc),
                32'(v.branch & v.zero & ~stl));
            chk({tag, " branch_target"}, o.bt, v.npc);
            chk({tag, " align_err"}, 32'(o.aerr), 32'd0);
            @(posedge clk);
            #1;
            if (stl) begin
                e[d].wbc = 2'b00;
            end else begin
                idx = v.alu[9:2];
                e[d].wbc  = v.wb_ctl;
                e[d].alu  = v.alu;
                e[d].wreg = v.rd;
                e[d].rdat = v.memread ? mm[d][idx] : 32'd0;
                if (v.memwrite) mm[d][idx] = v.wdata;
            end
            check_regs(d, tag);
        end
        drive(d, '0);
        stale[1-d] = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in0 = mk(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 5'd1);
        in1 = in0;
        @(negedge clk);
        chk("reset mem_stall L1", 32'(s0), 32'd0);
        chk("reset mem_stall L3", 32'(s1), 32'd0);
        chk("reset pcsrc L3", 32'(p1), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        e[0] = '0; e[1] = '0;
        check_regs(0, "reset L1");
        check_regs(1, "reset L3");
        reset = 1'b0;
        in0 = '0; in1 = '0;
        stale[0] = 0; stale[1] = 0;
    endtask

    vec_t tbl [10];

    initial begin
        in_t v;
        logic [31:0] r;
        int d, k;
        logic [31:0] old8;

        tbl[0] = '{0, mk(2'b10, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd3), 0, 0};
        tbl[1] = '{0, mk(2'b11, 0, 1, 0, 0, 0, 32'h10, 32'h0, 5'd7), 1, 32'hDEADBEEF};
        tbl[2] = '{1, mk(2'b10, 0, 0, 1, 0, 0, 32'h20, 32'h12345678, 5'd0), 0, 0};
        tbl[3] = '{1, mk(2'b11, 0, 1, 0, 0, 0, 32'h20, 32'h0, 5'd9), 1, 32'h12345678};
        tbl[4] = '{1, mk(2'b00, 1, 0, 0, 1, 32'h40, 32'h5, 32'h0, 5'd0), 1, 32'h0};
        tbl[5] = '{1, mk(2'b00, 1, 0, 0, 0, 32'h40, 32'h5, 32'h0, 5'd0), 1, 32'h0};
        tbl[6] = '{1, mk(2'b10, 0, 0, 1, 0, 0, 32'h400, 32'h11, 5'd0), 0, 0};
        tbl[7] = '{1, mk(2'b11, 0, 1, 0, 0, 0, 32'h000, 32'h0, 5'd4), 1, 32'h11};
        tbl[8] = '{1, mk(2'b11, 0, 1, 1, 0, 0, 32'h20, 32'hCAFEF00D, 5'd5), 1, 32'h12345678};
        tbl[9] = '{0, mk(2'b11, 0, 1, 0, 0, 0, 32'h410, 32'h0, 5'd6), 1, 32'hDEADBEEF};

        reset = 1'b0;
        in0 = '0; in1 = '0;
        e[0] = '0; e[1] = '0;
        stale[0] = 0; stale[1] = 0;
        @(posedge clk);
        #1;
        do_reset();

        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < 16; i++) begin
                r = $urandom();
                issue(dd, mk(2'b00, 0, 0, 1, 0, 0, 32'(i * 4), r, 5'd0));
            end

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].d, tbl[i].i);
            if (tbl[i].chk)
                chk($sformatf("vec%0d read_data", i),
                    get(tbl[i].d).rdat, tbl[i].exp_rd);
        end
        issue(1, mk(2'b11, 0, 1, 0, 0, 0, 32'h20, 32'h0, 5'd2));
        chk("rmw new word", o1.rdat, 32'hCAFEF00D);

        // Store abandoned by reset during its second stall cycle
        old8 = mm[1][2];
        in1 = mk(2'b10, 0, 0, 1, 0, 0, 32'h08, 32'hAAAA5555, 5'd0);
        @(negedge clk);
        chk("abort stall c0", 32'(s1), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort stall forced 0", 32'(s1), 32'd0);
        @(posedge clk);
        #1;
        e[0] = '0; e[1] = '0;
        check_regs(1, "abort L3");
        check_regs(0, "abort L1");
        reset = 1'b0;
        in0 = '0; in1 = '0;
        stale[0] = 0; stale[1] = 0;
        issue(1, mk(2'b11, 0, 1, 0, 0, 0, 32'h08, 32'h0, 5'd8));
        chk("abort RAM kept", o1.rdat, old8);

        for (int i = 0; i < 300; i++) begin
            d = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 3));
            r = $urandom();
            v.npc = $urandom();
            v.wdata = $urandom();
            v.rd = r[4:0];
            v.alu = {r[31:10], 4'(r[9:6]), 2'b00, r[1:0]};
            v.wb_ctl = r[6:5];
            v.branch = 1'b0; v.zero = 1'b0;
            v.memread = 1'b0; v.memwrite = 1'b0;
            case (k)
                0: begin v.wb_ctl = 2'b00; v.rd = 5'd0; end
                1: v.memread = 1'b1;
                2: v.memwrite = 1'b1;
                default: begin v.branch = r[7]; v.zero = r[8]; end
            endcase
            issue(d, v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
